intersection_controller: RTL and testbench
==========================================

# intersection_controller

Cycle-driven controller for a four-way, two-street intersection. The horizontal street runs West/East and the vertical street runs North/South. It sequences four vehicle signal heads and eight pedestrian signal heads, with green time scaled by per-street traffic load. It serves pedestrian push-buttons and a police override, and includes a small two-bank traffic-count memory readable and writable from outside. It sits at the top of the traffic-light design, driven directly by board inputs.

## Interface
- No parameters. Constants live in the package.
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- police_Interrupt  in  1  level; while high, override to all-stop
- pedestrian_Hori_Street_Interrupt  in  1  button to cross horizontal street (pulse, latched)
- pedestrian_Vert_Street_Interrupt  in  1  button to cross vertical street (pulse, latched)
- traffic_Street_0  in  4  horizontal-street traffic load / memory write data bank 0
- traffic_Street_1  in  4  vertical-street traffic load / memory write data bank 1
- read_Write  in  1  1 = write, 0 = read (qualified by memory_Enable)
- memory_Enable  in  1  memory access strobe
- address  in  7  memory word address (128 words per bank)
- street  in  1  read bank select: 0 = horizontal, 1 = vertical
- traffic_Street  out  4  registered memory read data
- led_North, led_South, led_West, led_East  out  3 each  vehicle heads {red,yellow,green}, one-hot
- led_Hori_North_East, led_Hori_North_West, led_Hori_South_East, led_Hori_South_West  out  2 each  horizontal-crossing pedestrian heads {dont_walk,walk}
- led_Vert_North_East, led_Vert_North_West, led_Vert_South_East, led_Vert_South_West  out  2 each  vertical-crossing pedestrian heads {dont_walk,walk}

## Operation
- Vehicle encoding: RED=3'b100, YELLOW=3'b010, GREEN=3'b001. Pedestrian encoding: DONT_WALK=2'b10, WALK=2'b01.
- West/East share the horizontal state. North/South share the vertical state.
- FSM states:
  - ALLRED_H: all red, 1 cycle, next H_GREEN
  - H_GREEN: West/East green
  - H_YELLOW: 3 cycles
  - ALLRED_V: 1 cycle
  - V_GREEN: North/South green
  - V_YELLOW: 3 cycles, next ALLRED_H
  - POLICE: all vehicle red, all pedestrian dont_walk
- Green duration:
  - On entry to H_GREEN, duration = 4 + traffic_Street_0 (4..19 cycles).
  - On entry to V_GREEN, duration = 4 + traffic_Street_1.
  - The load value is sampled on the entry cycle and held.
- Pedestrian walk:
  - Vert heads (crossing the vertical street) show WALK only in H_GREEN.
  - Hori heads show WALK only in V_GREEN.
  - All other states show DONT_WALK.
- Pedestrian request:
  - A pedestrian_Hori pulse sets req_h.
  - If the state is H_GREEN and its elapsed count ≥ 4, H_GREEN ends at the next edge; otherwise it ends when the count reaches 4.
  - req_h clears on entry to V_GREEN.
  - pedestrian_Vert / req_v behave symmetrically against V_GREEN.
  - A request arriving in the serving green itself is held for the next cycle of the sequence.
- Police override:
  - While police_Interrupt is high at an edge, next state is POLICE, from any state.
  - The first low sample moves POLICE to ALLRED_H.
  - Pending pedestrian requests are preserved.
- Memory: two banks, each 128×4.
  - Write (memory_Enable=1, read_Write=1): mem0[address] ← traffic_Street_0 and mem1[address] ← traffic_Street_1 at the same edge.
  - Read (memory_Enable=1, read_Write=0): traffic_Street ← mem{street}[address], valid the next cycle.
  - With memory_Enable=0, traffic_Street holds its value.
  - Memory contents are not reset.
- Reset values:
  - State ALLRED_H; counter 0; req_h = req_v = 0.
  - All vehicle heads RED; all pedestrian heads DONT_WALK.
  - traffic_Street = 0.

## Timing
- All outputs are registered or decoded from the registered state. No combinational input-to-output paths.
- After reset deasserts at edge 0:
  - Cycle 0: ALLRED_H
  - Cycles 1..(4+load): H_GREEN
  - Then 3 cycles H_YELLOW, 1 cycle ALLRED_V, then V_GREEN.
- Police has priority over pedestrian truncation and phase timeout in the same cycle. Reset has priority over everything.
- A memory write and read never coincide (one read_Write bit). Read-after-write to the same address returns the new data one cycle after the read strobe.
- Load values of 15 give a 19-cycle green. The counter is 5 bits and must not wrap.

## Structure
- Package intersection_pkg holds:
  - state enum
  - the LED encodings
  - YELLOW_CYCLES=3, ALLRED_CYCLES=1, MIN_GREEN=4
  - MEM_DEPTH=128
- Sub-module traffic_memory holds the two-bank 128×4 RAM with registered read. The FSM, counter and LED decode stay in the top module.

## Test plan
- Reset, then release with loads 0/0:
  - cycle 0 all LEDs RED
  - cycles 1–4 West/East = 001 and Vert peds = 01
  - cycles 5–7 West/East = 010
  - cycle 8 all red
  - cycles 9–12 North/South = 001 and Hori peds = 01
- traffic_Street_0=15 → H_GREEN lasts exactly 19 cycles.
- With load 10, pulse pedestrian_Hori at H_GREEN cycle 6 → H_YELLOW next cycle; req_h clears on entry to V_GREEN.
- Raise police_Interrupt mid-V_GREEN for 5 cycles → all heads RED/DONT_WALK next edge; after release, one ALLRED_H cycle then H_GREEN.
- Write 4'hA/4'h5 at address 7'd42; read with street=0 → traffic_Street = 4'hA next cycle; street=1 → 4'h5.
- Assert reset during H_YELLOW → next cycle ALLRED_H, all RED, traffic_Street = 0.

Source files
------------

// File: rtl/intersection_pkg.sv
// Shared types and constants for the intersection controller.
package intersection_pkg;

    typedef enum logic [2:0] {
        ALLRED_H,
        H_GREEN,
        H_YELLOW,
        ALLRED_V,
        V_GREEN,
        V_YELLOW,
        POLICE
    } state_e;

    // Vehicle heads are {red,yellow,green}; pedestrian heads are {dont_walk,walk}.
    localparam logic [2:0] LED_RED       = 3'b100;
    localparam logic [2:0] LED_YELLOW    = 3'b010;
    localparam logic [2:0] LED_GREEN     = 3'b001;
    localparam logic [1:0] PED_DONT_WALK = 2'b10;
    localparam logic [1:0] PED_WALK      = 2'b01;

    localparam int unsigned YELLOW_CYCLES = 3;
    localparam int unsigned ALLRED_CYCLES = 1;
    localparam int unsigned MIN_GREEN     = 4;
    localparam int unsigned MEM_DEPTH     = 128;

endpackage

// File: rtl/traffic_memory.sv
// Two-bank 128x4 traffic-count RAM: both banks written together, one bank read
// into a registered output that holds while no read is requested.
module traffic_memory
    import intersection_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       we_i,
    input  logic       re_i,
    input  logic [6:0] addr_i,
    input  logic [3:0] wdata0_i,
    input  logic [3:0] wdata1_i,
    input  logic       bank_i,
    output logic [3:0] rdata_o
);

    logic [3:0] mem0_q [MEM_DEPTH];
    logic [3:0] mem1_q [MEM_DEPTH];
    logic [3:0] rdata_q;

    // Contents are deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem0_q[addr_i] <= wdata0_i;
            mem1_q[addr_i] <= wdata1_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= bank_i ? mem1_q[addr_i] : mem0_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/intersection_controller.sv
// Two-street intersection sequencer with load-scaled green, pedestrian
// truncation, police all-stop override and a two-bank traffic-count memory.
module intersection_controller
    import intersection_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       police_Interrupt,
    input  logic       pedestrian_Hori_Street_Interrupt,
    input  logic       pedestrian_Vert_Street_Interrupt,
    input  logic [3:0] traffic_Street_0,
    input  logic [3:0] traffic_Street_1,
    input  logic       read_Write,
    input  logic       memory_Enable,
    input  logic [6:0] address,
    input  logic       street,
    output logic [3:0] traffic_Street,
    output logic [2:0] led_North,
    output logic [2:0] led_South,
    output logic [2:0] led_West,
    output logic [2:0] led_East,
    output logic [1:0] led_Hori_North_East,
    output logic [1:0] led_Hori_North_West,
    output logic [1:0] led_Hori_South_East,
    output logic [1:0] led_Hori_South_West,
    output logic [1:0] led_Vert_North_East,
    output logic [1:0] led_Vert_North_West,
    output logic [1:0] led_Vert_South_East,
    output logic [1:0] led_Vert_South_West
);

    state_e     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [4:0] dur_q, dur_d;
    logic       req_h_q, req_h_d;
    logic       req_v_q, req_v_d;
    logic       req_h_now, req_v_now;
    logic [2:0] veh_ns, veh_we;
    logic [1:0] ped_hori, ped_vert;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ALLRED_H;
            cnt_q   <= '0;
            dur_q   <= 5'(MIN_GREEN);
            req_h_q <= 1'b0;
            req_v_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dur_q   <= dur_d;
            req_h_q <= req_h_d;
            req_v_q <= req_v_d;
        end
    end

    // A button pulse counts in the same cycle it arrives, so an eligible green
    // ends on the very next edge rather than one cycle after the latch.
    always_comb begin
        state_d   = state_q;
        dur_d     = dur_q;
        req_h_now = req_h_q | pedestrian_Hori_Street_Interrupt;
        req_v_now = req_v_q | pedestrian_Vert_Street_Interrupt;

        if (police_Interrupt) begin
            state_d = POLICE;
        end else begin
            case (state_q)
                ALLRED_H: if (cnt_q == 5'(ALLRED_CYCLES - 1)) state_d = H_GREEN;
                H_GREEN:  if ((cnt_q == dur_q - 5'd1) ||
                              (req_h_now && cnt_q >= 5'(MIN_GREEN - 1))) state_d = H_YELLOW;
                H_YELLOW: if (cnt_q == 5'(YELLOW_CYCLES - 1)) state_d = ALLRED_V;
                ALLRED_V: if (cnt_q == 5'(ALLRED_CYCLES - 1)) state_d = V_GREEN;
                V_GREEN:  if ((cnt_q == dur_q - 5'd1) ||
                              (req_v_now && cnt_q >= 5'(MIN_GREEN - 1))) state_d = V_YELLOW;
                V_YELLOW: if (cnt_q == 5'(YELLOW_CYCLES - 1)) state_d = ALLRED_H;
                default:  state_d = ALLRED_H;
            endcase
        end

        if (state_d == H_GREEN && state_q != H_GREEN) begin
            dur_d = 5'(MIN_GREEN) + {1'b0, traffic_Street_0};
        end else if (state_d == V_GREEN && state_q != V_GREEN) begin
            dur_d = 5'(MIN_GREEN) + {1'b0, traffic_Street_1};
        end

        // Counter saturates so a long police hold cannot wrap it.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == '1) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 5'd1;
        end

        req_h_d = pedestrian_Hori_Street_Interrupt |
                  (req_h_q & ~(state_d == V_GREEN && state_q != V_GREEN));
        req_v_d = pedestrian_Vert_Street_Interrupt |
                  (req_v_q & ~(state_d == H_GREEN && state_q != H_GREEN));
    end

    always_comb begin
        veh_ns   = LED_RED;
        veh_we   = LED_RED;
        ped_hori = PED_DONT_WALK;
        ped_vert = PED_DONT_WALK;
        case (state_q)
            H_GREEN: begin
                veh_we   = LED_GREEN;
                ped_vert = PED_WALK;
            end
            H_YELLOW: veh_we = LED_YELLOW;
            V_GREEN: begin
                veh_ns   = LED_GREEN;
                ped_hori = PED_WALK;
            end
            V_YELLOW: veh_ns = LED_YELLOW;
            default: ;
        endcase
    end

    assign led_North           = veh_ns;
    assign led_South           = veh_ns;
    assign led_West            = veh_we;
    assign led_East            = veh_we;
    assign led_Hori_North_East = ped_hori;
    assign led_Hori_North_West = ped_hori;
    assign led_Hori_South_East = ped_hori;
    assign led_Hori_South_West = ped_hori;
    assign led_Vert_North_East = ped_vert;
    assign led_Vert_North_West = ped_vert;
    assign led_Vert_South_East = ped_vert;
    assign led_Vert_South_West = ped_vert;

    traffic_memory u_mem (
        .clk_i    (clock),
        .rst_i    (reset),
        .we_i     (memory_Enable & read_Write),
        .re_i     (memory_Enable & ~read_Write),
        .addr_i   (address),
        .wdata0_i (traffic_Street_0),
        .wdata1_i (traffic_Street_1),
        .bank_i   (street),
        .rdata_o  (traffic_Street)
    );

endmodule

// File: tb/tb_intersection_controller.sv
// Directed bench for intersection_controller: phase timing, load scaling,
// pedestrian truncation, police override, memory access and mid-run reset.
module tb_intersection_controller;

    localparam logic [2:0] R  = 3'b100;
    localparam logic [2:0] Y  = 3'b010;
    localparam logic [2:0] G  = 3'b001;
    localparam logic [1:0] DW = 2'b10;
    localparam logic [1:0] WK = 2'b01;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       police = 1'b0;
    logic       ph = 1'b0;
    logic       pv = 1'b0;
    logic [3:0] t0 = 4'd0;
    logic [3:0] t1 = 4'd0;
    logic       rw = 1'b0;
    logic       me = 1'b0;
    logic [6:0] addr = 7'd0;
    logic       street = 1'b0;

    logic [3:0] ts;
    logic [2:0] lN, lS, lW, lE;
    logic [1:0] hNE, hNW, hSE, hSW, vNE, vNW, vSE, vSW;
    logic [11:0] veh;
    logic [15:0] ped;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    assign veh = {lN, lS, lW, lE};
    assign ped = {hNE, hNW, hSE, hSW, vNE, vNW, vSE, vSW};

    intersection_controller dut (
        .clock                            (clock),
        .reset                            (reset),
        .police_Interrupt                 (police),
        .pedestrian_Hori_Street_Interrupt (ph),
        .pedestrian_Vert_Street_Interrupt (pv),
        .traffic_Street_0                 (t0),
        .traffic_Street_1                 (t1),
        .read_Write                       (rw),
        .memory_Enable                    (me),
        .address                          (addr),
        .street                           (street),
        .traffic_Street                   (ts),
        .led_North                        (lN),
        .led_South                        (lS),
        .led_West                         (lW),
        .led_East                         (lE),
        .led_Hori_North_East              (hNE),
        .led_Hori_North_West              (hNW),
        .led_Hori_South_East              (hSE),
        .led_Hori_South_West              (hSW),
        .led_Vert_North_East              (vNE),
        .led_Vert_North_West              (vNW),
        .led_Vert_South_East              (vSE),
        .led_Vert_South_West              (vSW)
    );

    function automatic logic [11:0] ev(logic [2:0] ns, logic [2:0] we);
        return {ns, ns, we, we};
    endfunction

    function automatic logic [15:0] ep(logic hw, logic vw);
        return {{4{hw ? WK : DW}}, {4{vw ? WK : DW}}};
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Leaves the DUT in cycle 0 (ALLRED_H) with reset still high.
    task automatic do_reset;
        reset = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if (veh !== ev(R, R)) begin
            errors++;
            $display("FAIL reset_veh got=%h want=%h", veh, ev(R, R));
        end
        checks++;
        if (ped !== ep(1'b0, 1'b0)) begin
            errors++;
            $display("FAIL reset_ped got=%h want=%h", ped, ep(1'b0, 1'b0));
        end
        checks++;
        if (ts !== 4'd0) begin
            errors++;
            $display("FAIL reset_ts got=%h want=0", ts);
        end
    endtask

    task automatic test_sequence;
        logic [2:0] ens, ewe;
        logic       hw, vw;
        t0 = 4'd0;
        t1 = 4'd0;
        do_reset();
        reset = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            ens = R; ewe = R; hw = 1'b0; vw = 1'b0;
            if (c <= 4) begin
                ewe = G; vw = 1'b1;
            end else if (c <= 7) begin
                ewe = Y;
            end else if (c >= 9) begin
                ens = G; hw = 1'b1;
            end
            checks++;
            if (veh !== ev(ens, ewe)) begin
                errors++;
                $display("FAIL seq_veh cycle=%0d got=%h want=%h", c, veh, ev(ens, ewe));
            end
            checks++;
            if (ped !== ep(hw, vw)) begin
                errors++;
                $display("FAIL seq_ped cycle=%0d got=%h want=%h", c, ped, ep(hw, vw));
            end
        end
    endtask

    task automatic test_long_green;
        logic [2:0] ewe;
        t0 = 4'd15;
        t1 = 4'd0;
        do_reset();
        reset = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            ewe = (c <= 19) ? G : Y;
            checks++;
            if (veh !== ev(R, ewe)) begin
                errors++;
                $display("FAIL long_green cycle=%0d got=%h want=%h", c, veh, ev(R, ewe));
            end
        end
    endtask

    task automatic test_ped_truncate;
        logic [2:0] ens, ewe;
        t0 = 4'd10;
        t1 = 4'd0;
        do_reset();
        reset = 1'b0;
        for (int c = 1; c <= 33; c++) begin
            tick();
            ens = R; ewe = R;
            if (c <= 6 || (c >= 19 && c <= 32)) ewe = G;
            else if (c <= 9 || c == 33)         ewe = Y;
            else if (c >= 11 && c <= 14)        ens = G;
            else if (c >= 15 && c <= 17)        ens = Y;
            checks++;
            if (veh !== ev(ens, ewe)) begin
                errors++;
                $display("FAIL ped_truncate cycle=%0d got=%h want=%h", c, veh, ev(ens, ewe));
            end
            ph = (c == 6);
        end
        ph = 1'b0;
    endtask

    task automatic test_ped_early;
        logic [2:0] ens, ewe;
        t0 = 4'd0;
        t1 = 4'd10;
        do_reset();
        reset = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            tick();
            ens = R; ewe = R;
            if (c <= 4)       ewe = G;
            else if (c <= 7)  ewe = Y;
            else if (c >= 9 && c <= 12) ens = G;
            else if (c == 13) ens = Y;
            checks++;
            if (veh !== ev(ens, ewe)) begin
                errors++;
                $display("FAIL ped_early cycle=%0d got=%h want=%h", c, veh, ev(ens, ewe));
            end
            pv = (c == 9);
        end
        pv = 1'b0;
    endtask

    task automatic test_police;
        logic [2:0] ens, ewe;
        logic       hw, vw;
        t0 = 4'd0;
        t1 = 4'd0;
        do_reset();
        reset = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            tick();
            ens = R; ewe = R; hw = 1'b0; vw = 1'b0;
            if (c <= 4 || (c >= 17 && c <= 20)) begin
                ewe = G; vw = 1'b1;
            end else if (c <= 7 || c == 21) begin
                ewe = Y;
            end else if (c == 9 || c == 10) begin
                ens = G; hw = 1'b1;
            end
            checks++;
            if (veh !== ev(ens, ewe)) begin
                errors++;
                $display("FAIL police_veh cycle=%0d got=%h want=%h", c, veh, ev(ens, ewe));
            end
            checks++;
            if (ped !== ep(hw, vw)) begin
                errors++;
                $display("FAIL police_ped cycle=%0d got=%h want=%h", c, ped, ep(hw, vw));
            end
            police = (c >= 10 && c <= 14);
            ph = (c == 12);
            if (c == 12) t0 = 4'd5;
        end
        police = 1'b0;
        ph = 1'b0;
        t0 = 4'd0;
    endtask

    task automatic test_memory;
        me = 1'b1; rw = 1'b1; addr = 7'd42; t0 = 4'hA; t1 = 4'h5;
        tick();
        rw = 1'b0; street = 1'b0;
        tick();
        checks++;
        if (ts !== 4'hA) begin
            errors++;
            $display("FAIL mem_read_bank0 got=%h want=a", ts);
        end
        street = 1'b1;
        tick();
        checks++;
        if (ts !== 4'h5) begin
            errors++;
            $display("FAIL mem_read_bank1 got=%h want=5", ts);
        end
        me = 1'b0; street = 1'b0; addr = 7'd0;
        tick();
        checks++;
        if (ts !== 4'h5) begin
            errors++;
            $display("FAIL mem_hold got=%h want=5", ts);
        end
        me = 1'b1; rw = 1'b1; addr = 7'd42; t0 = 4'h3; t1 = 4'hC;
        tick();
        rw = 1'b0; street = 1'b0;
        tick();
        checks++;
        if (ts !== 4'h3) begin
            errors++;
            $display("FAIL mem_raw got=%h want=3", ts);
        end
        rw = 1'b1; addr = 7'd127; t0 = 4'h1; t1 = 4'h2;
        tick();
        rw = 1'b0; street = 1'b1;
        tick();
        checks++;
        if (ts !== 4'h2) begin
            errors++;
            $display("FAIL mem_top_addr got=%h want=2", ts);
        end
        addr = 7'd42;
        tick();
        checks++;
        if (ts !== 4'hC) begin
            errors++;
            $display("FAIL mem_other_addr got=%h want=c", ts);
        end
        me = 1'b0; street = 1'b0; t0 = 4'd0; t1 = 4'd0;
    endtask

    task automatic test_reset_mid;
        t0 = 4'd0;
        t1 = 4'd0;
        do_reset();
        reset = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 2) begin
                checks++;
                if (ts !== 4'h3) begin
                    errors++;
                    $display("FAIL mid_read got=%h want=3", ts);
                end
            end
            me = (c == 1); rw = 1'b0; street = 1'b0; addr = 7'd42;
        end
        checks++;
        if (veh !== ev(R, Y)) begin
            errors++;
            $display("FAIL mid_yellow got=%h want=%h", veh, ev(R, Y));
        end
        reset = 1'b1;
        tick();
        checks++;
        if (veh !== ev(R, R) || ped !== ep(1'b0, 1'b0)) begin
            errors++;
            $display("FAIL mid_reset_leds got=%h/%h want=%h/%h", veh, ped, ev(R, R), ep(1'b0, 1'b0));
        end
        checks++;
        if (ts !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset_ts got=%h want=0", ts);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (veh !== ev(R, G)) begin
            errors++;
            $display("FAIL mid_restart got=%h want=%h", veh, ev(R, G));
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_long_green();
        test_ped_truncate();
        test_ped_early();
        test_police();
        test_memory();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
